axi_arbiter: RTL

AXI_ARBITER -- requirements
Module: axi_arbiter

---
 rtl/axi_arb_pkg.sv | 22 ++
 rtl/axi_arb_wr.sv | 110 +++++++++++
 rtl/axi_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - FSM states, AXI IDs and request type encodings for axi_arbiter
package axi_arb_pkg;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;

    typedef enum logic [2:0] {
        TYPE_BYTE = 3'b000,
        TYPE_HALF = 3'b001,
        TYPE_WORD = 3'b010,
        TYPE_LINE = 3'b100
    } req_type_t;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    // Line bursts always move 32-bit beats; singles carry their size in type[1:0].
    function automatic logic [2:0] ax_size(input logic [2:0] req_type);
        return (req_type == TYPE_LINE) ? 3'd2 : {1'b0, req_type[1:0]};
    endfunction

endpackage

// File: rtl/axi_arb_wr.sv
// rtl/axi_arb_wr.sv - dcache write path: request buffer, AW/W/B sequencing and beat counter
module axi_arb_wr
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BEATS = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              wr_req,
    input  logic [2:0]        wr_type,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_wstrb,
    input  logic [127:0]      wr_data,
    output logic              wr_rdy,
    output logic              wr_done,
    output logic              busy,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    wr_state_t    state;
    logic [2:0]   buf_type;
    logic [3:0]   buf_wstrb;
    logic [127:0] buf_data;
    logic [1:0]   cnt;
    logic         line;

    assign line   = (buf_type == TYPE_LINE);
    assign busy   = (state != W_IDLE);
    assign awid   = ID_DATA;
    assign wid    = ID_DATA;
    assign awlen  = line ? 8'(LINE_BEATS - 1) : 8'd0;
    assign awsize = ax_size(buf_type);
    assign wdata  = buf_data[{cnt, 5'd0} +: 32];
    assign wstrb  = line ? 4'hF : buf_wstrb;
    assign wlast  = ({6'd0, cnt} == awlen);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= W_IDLE;
            awaddr    <= '0;
            buf_type  <= '0;
            buf_wstrb <= '0;
            buf_data  <= '0;
            cnt       <= '0;
            wr_rdy    <= 1'b0;
            wr_done   <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (state)
                W_IDLE: begin
                    wr_rdy <= 1'b1;
                    if (wr_req && wr_rdy) begin
                        awaddr    <= wr_addr;
                        buf_type  <= wr_type;
                        buf_wstrb <= wr_wstrb;
                        buf_data  <= wr_data;
                        wr_rdy    <= 1'b0;
                        awvalid   <= 1'b1;
                        state     <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        cnt     <= '0;
                        state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid && wready) begin
                        cnt <= cnt + 2'd1;
                        if (wlast) begin
                            wvalid <= 1'b0;
                            bready <= 1'b1;
                            state  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        wr_done <= 1'b1;
                        wr_rdy  <= 1'b1;
                        state   <= W_IDLE;
                    end
                end
                default: state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_arbiter.sv
// rtl/axi_arbiter.sv - icache/dcache to AXI arbiter; read FSM here, writes in axi_arb_wr.
// AXI_ARB_RAW_CHECK_EN: block reads only on a line-address match with the pending write.
module axi_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BEATS = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              ic_rd_req,
    input  logic [2:0]        ic_rd_type,
    input  logic [ADDR_W-1:0] ic_rd_addr,
    output logic              ic_rd_rdy,
    output logic              ic_ret_valid,
    output logic              ic_ret_last,
    output logic [31:0]       ic_ret_data,
    input  logic              dc_rd_req,
    input  logic [2:0]        dc_rd_type,
    input  logic [ADDR_W-1:0] dc_rd_addr,
    output logic              dc_rd_rdy,
    output logic              dc_ret_valid,
    output logic              dc_ret_last,
    output logic [31:0]       dc_ret_data,
    input  logic              dc_wr_req,
    input  logic [2:0]        dc_wr_type,
    input  logic [ADDR_W-1:0] dc_wr_addr,
    input  logic [3:0]        dc_wr_wstrb,
    input  logic [127:0]      dc_wr_data,
    output logic              dc_wr_rdy,
    output logic              dc_wr_done,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    rd_state_t  r_state;
    logic [2:0] r_type;
    logic       wr_busy;
    logic       ic_block, dc_block, ic_go, dc_go;
    logic       unused;

    assign unused = &{1'b0, rresp, bresp, bid};

    axi_arb_wr #(.ADDR_W(ADDR_W), .LINE_BEATS(LINE_BEATS)) u_wr (
        .aclk(aclk), .areset(areset),
        .wr_req(dc_wr_req), .wr_type(dc_wr_type), .wr_addr(dc_wr_addr),
        .wr_wstrb(dc_wr_wstrb), .wr_data(dc_wr_data),
        .wr_rdy(dc_wr_rdy), .wr_done(dc_wr_done), .busy(wr_busy),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

`ifdef AXI_ARB_RAW_CHECK_EN
    assign ic_block = wr_busy && (ic_rd_addr[ADDR_W-1:4] == awaddr[ADDR_W-1:4]);
    assign dc_block = wr_busy && (dc_rd_addr[ADDR_W-1:4] == awaddr[ADDR_W-1:4]);
`else
    assign ic_block = wr_busy;
    assign dc_block = wr_busy;
`endif

    assign dc_go = dc_rd_req && !dc_block;
    assign ic_go = ic_rd_req && !ic_block;

    assign arlen   = (r_type == TYPE_LINE) ? 8'(LINE_BEATS - 1) : 8'd0;
    assign arsize  = ax_size(r_type);
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'h0;
    assign arprot  = 3'h0;

    // Beats with an unrecognised rid are still accepted by rready, just not forwarded.
    assign ic_ret_valid = rready && rvalid && (rid == ID_INST);
    assign dc_ret_valid = rready && rvalid && (rid == ID_DATA);
    assign ic_ret_last  = ic_ret_valid && rlast;
    assign dc_ret_last  = dc_ret_valid && rlast;
    assign ic_ret_data  = rdata;
    assign dc_ret_data  = rdata;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= R_IDLE;
            araddr    <= '0;
            r_type    <= '0;
            arid      <= ID_INST;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            ic_rd_rdy <= 1'b0;
            dc_rd_rdy <= 1'b0;
        end else begin
            ic_rd_rdy <= 1'b0;
            dc_rd_rdy <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (dc_go) begin
                        araddr    <= dc_rd_addr;
                        r_type    <= dc_rd_type;
                        arid      <= ID_DATA;
                        dc_rd_rdy <= 1'b1;
                        arvalid   <= 1'b1;
                        r_state   <= R_AR;
                    end else if (ic_go) begin
                        araddr    <= ic_rd_addr;
                        r_type    <= ic_rd_type;
                        arid      <= ID_INST;
                        ic_rd_rdy <= 1'b1;
                        arvalid   <= 1'b1;
                        r_state   <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rlast) begin
                        rready  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
